tbcm_arbiter_client: RTL and testbench

Requester-side agent for the matrix arbiter. It buffers a packet stream from a local source, raises `o_request` toward an arbiter port, forwards beats onto the shared downstream channel only while granted, and pulses `o_free` on the final beat so the arbiter can release its held grant. Ownership is packet-atomic: the request is held across upstream gaps until `last` is sent. An optional beat limit forces the client to yield mid-packet.

---
 rtl/tbcm_arbiter_client.sv | 121 ++++++++++++
 tb/tb_tbcm_arbiter_client.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tbcm_arbiter_client.sv
// Requester-side agent for the matrix arbiter: buffers an upstream packet stream in a
// 2-entry FIFO, holds a request for a whole packet ownership and forwards beats while granted.
module tbcm_arbiter_client #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  output logic                  o_request,
  input  logic                  i_grant,
  output logic                  o_free,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic                  o_owner
);

  localparam int CNT_W   = (MAX_BEATS < 1) ? 1 : $clog2(MAX_BEATS + 1);
  localparam int ENTRY_W = DATA_WIDTH + 1;
  localparam bit HAS_LIMIT = (MAX_BEATS != 0);
  localparam logic [CNT_W-1:0] LIMIT_M1 = HAS_LIMIT ? CNT_W'(MAX_BEATS - 1) : '0;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ENTRY_W-1:0] mem_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         count_q, count_d;

  logic               full, empty;
  logic               wr_en, rd_en;
  logic               req;
  logic               end_own;
  logic [ENTRY_W-1:0] head;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign head  = mem_q[rd_ptr_q];

  // Request is held across upstream gaps for the whole ownership.
  assign req     = (state_q == OWN) || !empty;
  assign o_valid = !empty && i_grant && req;
  assign o_ready = !full;

  assign wr_en = i_valid && o_ready;
  assign rd_en = o_valid && i_ready;

  // Ownership ends on the packet's last beat, or when the beat limit forces a yield.
  assign end_own = rd_en && (head[DATA_WIDTH] || (HAS_LIMIT && (cnt_q == LIMIT_M1)));

  assign o_request = req;
  assign o_free    = end_own;
  assign o_owner   = (state_q == OWN);
  assign o_data    = head[DATA_WIDTH-1:0];
  assign o_last    = head[DATA_WIDTH];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset too, so o_data/o_last read zero out of reset.
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= {i_last, i_data};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (rd_en) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    if (rd_en && !end_own) state_d = OWN;
      OWN:     if (end_own) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (end_own) begin
      cnt_d = '0;
    end else if (rd_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_tbcm_arbiter_client.sv
// Directed bench for tbcm_arbiter_client: two unlimited clients sharing a small arbiter
// model, plus one client with a two-beat ownership limit.
module tb_tbcm_arbiter_client;

  localparam int DW = 32;

  typedef struct packed {
    logic          idle;
    logic [DW-1:0] d;
    logic          l;
  } src_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          v_i   [3];
  logic [DW-1:0] d_i   [3];
  logic          l_i   [3];
  logic          rdy_i [3];
  logic          g_drv [3];
  logic          gnt   [3];
  logic          ry_o  [3];
  logic          rq_o  [3];
  logic          fr_o  [3];
  logic          vo_o  [3];
  logic          lo_o  [3];
  logic          ow_o  [3];
  logic [DW-1:0] do_o  [3];

  logic arb_g [2];
  bit   arb_mode;
  bit   own_valid;
  bit   own_idx;
  bit   pri;

  int vectors;
  int miscompares;
  int cyc;
  int c0;

  src_t        src0 [$];
  src_t        src1 [$];
  src_t        src2 [$];
  logic [47:0] lg   [$];

  tbcm_arbiter_client #(.DATA_WIDTH(DW), .MAX_BEATS(0)) u_a (
    .clk(clk), .rst_n(rst_n), .i_valid(v_i[0]), .o_ready(ry_o[0]), .i_data(d_i[0]),
    .i_last(l_i[0]), .o_request(rq_o[0]), .i_grant(gnt[0]), .o_free(fr_o[0]),
    .o_valid(vo_o[0]), .i_ready(rdy_i[0]), .o_data(do_o[0]), .o_last(lo_o[0]), .o_owner(ow_o[0])
  );

  tbcm_arbiter_client #(.DATA_WIDTH(DW), .MAX_BEATS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .i_valid(v_i[1]), .o_ready(ry_o[1]), .i_data(d_i[1]),
    .i_last(l_i[1]), .o_request(rq_o[1]), .i_grant(gnt[1]), .o_free(fr_o[1]),
    .o_valid(vo_o[1]), .i_ready(rdy_i[1]), .o_data(do_o[1]), .o_last(lo_o[1]), .o_owner(ow_o[1])
  );

  tbcm_arbiter_client #(.DATA_WIDTH(DW), .MAX_BEATS(2)) u_y (
    .clk(clk), .rst_n(rst_n), .i_valid(v_i[2]), .o_ready(ry_o[2]), .i_data(d_i[2]),
    .i_last(l_i[2]), .o_request(rq_o[2]), .i_grant(gnt[2]), .o_free(fr_o[2]),
    .o_valid(vo_o[2]), .i_ready(rdy_i[2]), .o_data(do_o[2]), .o_last(lo_o[2]), .o_owner(ow_o[2])
  );

  // Two-port arbiter: combinational grant when free, held until the owner frees it,
  // round-robin priority between packets.
  always_comb begin
    arb_g[0] = 1'b0;
    arb_g[1] = 1'b0;
    if (own_valid) begin
      if (own_idx) arb_g[1] = 1'b1;
      else         arb_g[0] = 1'b1;
    end else if (!pri) begin
      if (rq_o[0])      arb_g[0] = 1'b1;
      else if (rq_o[1]) arb_g[1] = 1'b1;
    end else begin
      if (rq_o[1])      arb_g[1] = 1'b1;
      else if (rq_o[0]) arb_g[0] = 1'b1;
    end
  end

  always_comb begin
    gnt[0] = arb_mode ? arb_g[0] : g_drv[0];
    gnt[1] = arb_mode ? arb_g[1] : g_drv[1];
    gnt[2] = g_drv[2];
  end

  function automatic logic [5:0] st(int i);
    return {rq_o[i], vo_o[i], vo_o[i] & lo_o[i], fr_o[i], ow_o[i], ry_o[i]};
  endfunction

  function automatic logic [47:0] ent(int n, logic [31:0] d, logic l, logic f, int c);
    return {2'(n), d, l, f, 12'(c)};
  endfunction

  function automatic bit src_has(int i);
    case (i)
      0:       return src0.size() != 0;
      1:       return src1.size() != 0;
      default: return src2.size() != 0;
    endcase
  endfunction

  function automatic src_t src_head(int i);
    src_t s = '0;
    case (i)
      0:       if (src0.size() != 0) s = src0[0];
      1:       if (src1.size() != 0) s = src1[0];
      default: if (src2.size() != 0) s = src2[0];
    endcase
    return s;
  endfunction

  task automatic src_pop(int i);
    case (i)
      0:       void'(src0.pop_front());
      1:       void'(src1.pop_front());
      default: void'(src2.pop_front());
    endcase
  endtask

  task automatic src_push(int i, logic idle, logic [31:0] d, logic l);
    src_t s = {idle, d, l};
    case (i)
      0:       src0.push_back(s);
      1:       src1.push_back(s);
      default: src2.push_back(s);
    endcase
  endtask

  // Called at a falling edge: present upstream beats, then let outputs settle.
  task automatic cyc_begin();
    src_t s;
    for (int i = 0; i < 3; i++) begin
      s      = src_head(i);
      v_i[i] = src_has(i) && !s.idle;
      d_i[i] = s.d;
      l_i[i] = s.l;
    end
    #1;
  endtask

  // Record handshakes seen before the rising edge, update the arbiter after it.
  task automatic cyc_end();
    src_t s;
    bit   g;
    logic fr_s [2];
    logic any_g;
    for (int i = 0; i < 3; i++) begin
      s = src_head(i);
      if (src_has(i) && (s.idle || (v_i[i] && ry_o[i]))) src_pop(i);
      if (vo_o[i] && rdy_i[i]) lg.push_back({2'(i), do_o[i], lo_o[i], fr_o[i], 12'(cyc - c0)});
    end
    fr_s[0] = fr_o[0];
    fr_s[1] = fr_o[1];
    any_g   = arb_g[0] || arb_g[1];
    g       = arb_g[1];
    @(posedge clk);
    #1;
    if (!rst_n) begin
      own_valid = 1'b0;
      pri       = 1'b0;
    end else if (arb_mode) begin
      if (own_valid) begin
        if (fr_s[own_idx]) begin
          own_valid = 1'b0;
          pri       = !own_idx;
        end
      end else if (any_g) begin
        if (fr_s[g]) begin
          pri = !g;
        end else begin
          own_valid = 1'b1;
          own_idx   = g;
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    src0.delete();
    src1.delete();
    src2.delete();
    for (int i = 0; i < 3; i++) begin
      v_i[i]   = 1'b0;
      d_i[i]   = '0;
      l_i[i]   = 1'b0;
      rdy_i[i] = 1'b0;
      g_drv[i] = 1'b0;
    end
    arb_mode  = 1'b0;
    own_valid = 1'b0;
    own_idx   = 1'b0;
    pri       = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [38:0] rst_exp = {6'b000001, 1'b0, 32'h0};
    hold_reset();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({st(i), lo_o[i], do_o[i]} !== rst_exp) begin
        $display("FAIL reset_hold[%0d]: got %h want %h", i, {st(i), lo_o[i], do_o[i]}, rst_exp);
        miscompares++;
      end
    end
    release_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({st(i), lo_o[i], do_o[i]} !== rst_exp) begin
        $display("FAIL reset_release[%0d]: got %h want %h", i, {st(i), lo_o[i], do_o[i]}, rst_exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_single_beat();
    logic [5:0]  e_st [3] = '{6'b000001, 6'b111101, 6'b000001};
    logic [47:0] e_log    = ent(0, 32'hA5, 1'b1, 1'b1, 1);
    logic [47:0] got;
    g_drv[0] = 1'b1;
    rdy_i[0] = 1'b1;
    lg.delete();
    c0 = cyc;
    src_push(0, 1'b0, 32'hA5, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc_begin();
      vectors++;
      if (st(0) !== e_st[k]) begin
        $display("FAIL single_beat status c%0d: got %b want %b", k, st(0), e_st[k]);
        miscompares++;
      end
      cyc_end();
    end
    got = (lg.size() == 1) ? lg[0] : '1;
    vectors++;
    if (got !== e_log) begin
      $display("FAIL single_beat log: got %h (n=%0d) want %h", got, lg.size(), e_log);
      miscompares++;
    end
  endtask

  task automatic test_upstream_gap();
    logic [5:0]  e_st [9] = '{6'b000001, 6'b110001, 6'b110011, 6'b100011, 6'b100011,
                              6'b100011, 6'b110011, 6'b111111, 6'b000001};
    logic [47:0] e_log [4];
    logic [47:0] got;
    e_log = '{ent(0, 32'h11, 1'b0, 1'b0, 1), ent(0, 32'h22, 1'b0, 1'b0, 2),
              ent(0, 32'h33, 1'b0, 1'b0, 6), ent(0, 32'h44, 1'b1, 1'b1, 7)};
    g_drv[0] = 1'b1;
    rdy_i[0] = 1'b1;
    lg.delete();
    c0 = cyc;
    src_push(0, 1'b0, 32'h11, 1'b0);
    src_push(0, 1'b0, 32'h22, 1'b0);
    for (int k = 0; k < 3; k++) src_push(0, 1'b1, 32'h0, 1'b0);
    src_push(0, 1'b0, 32'h33, 1'b0);
    src_push(0, 1'b0, 32'h44, 1'b1);
    for (int k = 0; k < 9; k++) begin
      cyc_begin();
      vectors++;
      if (st(0) !== e_st[k]) begin
        $display("FAIL gap status c%0d: got %b want %b", k, st(0), e_st[k]);
        miscompares++;
      end
      cyc_end();
    end
    vectors++;
    if (lg.size() != 4) begin
      $display("FAIL gap log_len: got %0d want 4", lg.size());
      miscompares++;
    end
    for (int k = 0; k < 4; k++) begin
      got = (k < lg.size()) ? lg[k] : '1;
      vectors++;
      if (got !== e_log[k]) begin
        $display("FAIL gap beat%0d: got %h want %h", k, got, e_log[k]);
        miscompares++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [5:0]  e_st [13] = '{6'b000001, 6'b100001, 6'b100000, 6'b100000, 6'b100000,
                               6'b110000, 6'b110011, 6'b110010, 6'b110011, 6'b110010,
                               6'b111011, 6'b111111, 6'b000001};
    logic        g_seq [13] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    logic        r_seq [13] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 1};
    logic [47:0] e_log [4];
    logic [47:0] got;
    e_log = '{ent(0, 32'hE0, 1'b0, 1'b0, 5), ent(0, 32'hE1, 1'b0, 1'b0, 7),
              ent(0, 32'hE2, 1'b0, 1'b0, 9), ent(0, 32'hE3, 1'b1, 1'b1, 11)};
    lg.delete();
    c0 = cyc;
    for (int k = 0; k < 4; k++) src_push(0, 1'b0, 32'hE0 + 32'(k), k == 3);
    for (int k = 0; k < 13; k++) begin
      g_drv[0] = g_seq[k];
      rdy_i[0] = r_seq[k];
      cyc_begin();
      vectors++;
      if (st(0) !== e_st[k]) begin
        $display("FAIL backpressure status c%0d: got %b want %b", k, st(0), e_st[k]);
        miscompares++;
      end
      cyc_end();
    end
    vectors++;
    if (lg.size() != 4) begin
      $display("FAIL backpressure log_len: got %0d want 4", lg.size());
      miscompares++;
    end
    for (int k = 0; k < 4; k++) begin
      got = (k < lg.size()) ? lg[k] : '1;
      vectors++;
      if (got !== e_log[k]) begin
        $display("FAIL backpressure beat%0d: got %h want %h", k, got, e_log[k]);
        miscompares++;
      end
    end
  endtask

  task automatic test_forced_yield();
    logic [5:0]  e_st [7] = '{6'b000001, 6'b110001, 6'b110111, 6'b110001,
                              6'b110111, 6'b111101, 6'b000001};
    logic [47:0] e_log [5];
    logic [47:0] got;
    e_log = '{ent(2, 32'hF1, 1'b0, 1'b0, 1), ent(2, 32'hF2, 1'b0, 1'b1, 2),
              ent(2, 32'hF3, 1'b0, 1'b0, 3), ent(2, 32'hF4, 1'b0, 1'b1, 4),
              ent(2, 32'hF5, 1'b1, 1'b1, 5)};
    g_drv[2] = 1'b1;
    rdy_i[2] = 1'b1;
    lg.delete();
    c0 = cyc;
    for (int k = 1; k <= 5; k++) src_push(2, 1'b0, 32'hF0 + 32'(k), k == 5);
    for (int k = 0; k < 7; k++) begin
      cyc_begin();
      vectors++;
      if (st(2) !== e_st[k]) begin
        $display("FAIL yield status c%0d: got %b want %b", k, st(2), e_st[k]);
        miscompares++;
      end
      cyc_end();
    end
    vectors++;
    if (lg.size() != 5) begin
      $display("FAIL yield log_len: got %0d want 5", lg.size());
      miscompares++;
    end
    for (int k = 0; k < 5; k++) begin
      got = (k < lg.size()) ? lg[k] : '1;
      vectors++;
      if (got !== e_log[k]) begin
        $display("FAIL yield beat%0d: got %h want %h", k, got, e_log[k]);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [5:0]  e_pre  [3] = '{6'b000001, 6'b110001, 6'b110011};
    logic [5:0]  e_post [3] = '{6'b000001, 6'b111101, 6'b000001};
    logic [38:0] rst_exp = {6'b000001, 1'b0, 32'h0};
    logic [47:0] e_log [2];
    logic [47:0] got;
    e_log = '{ent(0, 32'hC0, 1'b0, 1'b0, 1), ent(0, 32'hC1, 1'b0, 1'b0, 2)};
    g_drv[0] = 1'b1;
    rdy_i[0] = 1'b1;
    lg.delete();
    c0 = cyc;
    for (int k = 0; k < 4; k++) src_push(0, 1'b0, 32'hC0 + 32'(k), k == 3);
    for (int k = 0; k < 3; k++) begin
      cyc_begin();
      vectors++;
      if (st(0) !== e_pre[k]) begin
        $display("FAIL reset_mid pre c%0d: got %b want %b", k, st(0), e_pre[k]);
        miscompares++;
      end
      cyc_end();
    end
    for (int k = 0; k < 2; k++) begin
      got = (k < lg.size()) ? lg[k] : '1;
      vectors++;
      if (got !== e_log[k]) begin
        $display("FAIL reset_mid beat%0d: got %h want %h", k, got, e_log[k]);
        miscompares++;
      end
    end
    hold_reset();
    vectors++;
    if ({st(0), lo_o[0], do_o[0]} !== rst_exp) begin
      $display("FAIL reset_mid asserted: got %h want %h", {st(0), lo_o[0], do_o[0]}, rst_exp);
      miscompares++;
    end
    @(negedge clk);
    #1;
    vectors++;
    if ({st(0), lo_o[0], do_o[0]} !== rst_exp) begin
      $display("FAIL reset_mid held: got %h want %h", {st(0), lo_o[0], do_o[0]}, rst_exp);
      miscompares++;
    end
    release_reset();
    g_drv[0] = 1'b1;
    rdy_i[0] = 1'b1;
    lg.delete();
    c0 = cyc;
    src_push(0, 1'b0, 32'h5A, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc_begin();
      vectors++;
      if (st(0) !== e_post[k]) begin
        $display("FAIL reset_mid post c%0d: got %b want %b", k, st(0), e_post[k]);
        miscompares++;
      end
      cyc_end();
    end
    got = (lg.size() == 1) ? lg[0] : '1;
    vectors++;
    if (got !== ent(0, 32'h5A, 1'b1, 1'b1, 1)) begin
      $display("FAIL reset_mid new_packet: got %h want %h", got, ent(0, 32'h5A, 1'b1, 1'b1, 1));
      miscompares++;
    end
  endtask

  task automatic test_two_clients();
    // {request_a, request_b, free_a, free_b} per cycle
    logic [3:0]  e_rf [11] = '{4'b0000, 4'b1100, 4'b1100, 4'b1110, 4'b1100, 4'b1100,
                               4'b1101, 4'b1000, 4'b1000, 4'b1010, 4'b0000};
    logic [47:0] e_log [9];
    logic [47:0] got;
    e_log = '{ent(0, 32'hA0, 1'b0, 1'b0, 1), ent(0, 32'hA1, 1'b0, 1'b0, 2),
              ent(0, 32'hA2, 1'b1, 1'b1, 3), ent(1, 32'hB0, 1'b0, 1'b0, 4),
              ent(1, 32'hB1, 1'b0, 1'b0, 5), ent(1, 32'hB2, 1'b1, 1'b1, 6),
              ent(0, 32'hA3, 1'b0, 1'b0, 7), ent(0, 32'hA4, 1'b0, 1'b0, 8),
              ent(0, 32'hA5, 1'b1, 1'b1, 9)};
    hold_reset();
    release_reset();
    arb_mode = 1'b1;
    rdy_i[0] = 1'b1;
    rdy_i[1] = 1'b1;
    lg.delete();
    c0 = cyc;
    for (int k = 0; k < 6; k++) src_push(0, 1'b0, 32'hA0 + 32'(k), (k == 2) || (k == 5));
    for (int k = 0; k < 3; k++) src_push(1, 1'b0, 32'hB0 + 32'(k), k == 2);
    for (int k = 0; k < 11; k++) begin
      cyc_begin();
      vectors++;
      if ({rq_o[0], rq_o[1], fr_o[0], fr_o[1]} !== e_rf[k]) begin
        $display("FAIL two_clients req/free c%0d: got %b want %b", k,
                 {rq_o[0], rq_o[1], fr_o[0], fr_o[1]}, e_rf[k]);
        miscompares++;
      end
      cyc_end();
    end
    vectors++;
    if (lg.size() != 9) begin
      $display("FAIL two_clients log_len: got %0d want 9", lg.size());
      miscompares++;
    end
    for (int k = 0; k < 9; k++) begin
      got = (k < lg.size()) ? lg[k] : '1;
      vectors++;
      if (got !== e_log[k]) begin
        $display("FAIL two_clients beat%0d: got %h want %h", k, got, e_log[k]);
        miscompares++;
      end
    end
    arb_mode = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    c0          = 0;
    test_reset();
    test_single_beat();
    test_upstream_gap();
    test_backpressure();
    test_forced_yield();
    test_reset_mid_packet();
    test_two_clients();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
